// File: rtl/rv_core_pkg.sv
// Shared RV32I core types: datapath widths, ALU opcodes and the ID/EX payload record.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] store_data;
    alu_op_e         alu_op;
    logic            funct7;
    logic [RA_W-1:0] rd;
    logic            rd_wen;
    logic            is_load;
  } id_ex_t;

  // Immediate ops only carry the sub/arith bit for SRAI; ADDI etc. must never subtract.
  function automatic logic imm_funct7(alu_op_e op, logic imm_bit10);
    return (op == ALU_SR) ? imm_bit10 : 1'b0;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority bypass select for one source register (EX > MEM > WB > register file).
// Bypassing is only built when ID_EX_FWD_EN is defined; x0 always reads as zero.
module operand_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic            ex_en,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_wen,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_data = rs_data;
    if (rs == '0)
      fwd_data = '0;
    else if (ex_en && ex_rd == rs)
      fwd_data = ex_data;
    else if (mem_wen && mem_rd == rs)
      fwd_data = mem_data;
    else if (wb_wen && wb_rd == rs)
      fwd_data = wb_data;
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{ex_en, ex_rd, ex_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data};
  assign fwd_data   = (rs == '0) ? '0 : rs_data;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: handshake, load-use bubble, flush and operand bypass for the ALU.
// Build option: define ID_EX_FWD_EN to enable the bypass network and load-use detection.
module id_ex_operand_stage
  import rv_core_pkg::*;
#(
  parameter int XLEN = rv_core_pkg::XLEN,
  parameter int RA_W = rv_core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_alu_op,
  input  logic            id_funct7,
  input  logic            id_use_imm,
  input  logic            id_use_pc,
  input  logic            id_rd_wen,
  input  logic            id_is_load,
  input  logic [XLEN-1:0] alu_result,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_wen,
  input  logic [XLEN-1:0] mem_data,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_wen,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] store_data,
  output logic [2:0]      alu_op,
  output logic            funct7,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_rd_wen,
  output logic            ex_is_load
);

  // The payload record is sized by the package, so overrides must agree with it.
  if (XLEN != rv_core_pkg::XLEN || RA_W != rv_core_pkg::RA_W) begin : g_param_check
    $error("id_ex_operand_stage: XLEN/RA_W must match rv_core_pkg");
  end

  id_ex_t          ex_reg;
  id_ex_t          ex_next;
  logic            adv;
  logic            luh;
  logic            capture;
  logic            ex_fwd_ok;
  logic [RA_W-1:0] rs_addr [2];
  logic [XLEN-1:0] rs_raw  [2];
  logic [XLEN-1:0] rs_fwd  [2];

  assign adv = !ex_reg.valid || ex_ready;

`ifdef ID_EX_FWD_EN
  assign luh = ex_reg.valid && ex_reg.is_load && (ex_reg.rd != '0) &&
               (id_rs1 == ex_reg.rd || (!id_use_imm && id_rs2 == ex_reg.rd));
`else
  assign luh = 1'b0;
`endif

  assign id_ready  = adv && !luh && !flush;
  assign capture   = id_valid && id_ready;
  // A held load has no result yet, so it is never a bypass source.
  assign ex_fwd_ok = ex_reg.valid && ex_reg.rd_wen && !ex_reg.is_load;

  assign rs_addr[0] = id_rs1;
  assign rs_addr[1] = id_rs2;
  assign rs_raw[0]  = id_rs1_data;
  assign rs_raw[1]  = id_rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    operand_fwd_mux #(
      .XLEN(XLEN),
      .RA_W(RA_W)
    ) u_fwd (
      .rs       (rs_addr[gi]),
      .rs_data  (rs_raw[gi]),
      .ex_en    (ex_fwd_ok),
      .ex_rd    (ex_reg.rd),
      .ex_data  (alu_result),
      .mem_wen  (mem_wen),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .wb_wen   (wb_wen),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .fwd_data (rs_fwd[gi])
    );
  end

  always_comb begin
    ex_next = ex_reg;
    if (flush) begin
      ex_next = '0;
    end else if (adv) begin
      // Empty slot (bubble or idle decode) carries a cleared payload.
      ex_next = '0;
      if (capture) begin
        ex_next.valid      = 1'b1;
        ex_next.operand_a  = id_use_pc ? id_pc : rs_fwd[0];
        ex_next.operand_b  = id_use_imm ? id_imm : rs_fwd[1];
        ex_next.store_data = rs_fwd[1];
        ex_next.alu_op     = alu_op_e'(id_alu_op);
        ex_next.funct7     = id_use_imm ? imm_funct7(alu_op_e'(id_alu_op), id_imm[10]) : id_funct7;
        ex_next.rd         = id_rd;
        ex_next.rd_wen     = id_rd_wen;
        ex_next.is_load    = id_is_load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ex_reg <= '0;
    else
      ex_reg <= ex_next;
  end

  assign ex_valid   = ex_reg.valid;
  assign operand_a  = ex_reg.operand_a;
  assign operand_b  = ex_reg.operand_b;
  assign store_data = ex_reg.store_data;
  assign alu_op     = ex_reg.alu_op;
  assign funct7     = ex_reg.funct7;
  assign ex_rd      = ex_reg.rd;
  assign ex_rd_wen  = ex_reg.rd_wen;
  assign ex_is_load = ex_reg.is_load;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed + short random stimulus for id_ex_operand_stage with a queue-based scoreboard.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_alu_op;
  logic        id_funct7, id_use_imm, id_use_pc, id_rd_wen, id_is_load;
  logic [31:0] alu_result, mem_data, wb_data;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_wen, wb_wen, ex_ready, flush;
  logic        ex_valid, funct7, ex_rd_wen, ex_is_load;
  logic [31:0] operand_a, operand_b, store_data;
  logic [2:0]  alu_op;
  logic [4:0]  ex_rd;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [2:0]  op;
    logic        f7;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_load;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_funct7(id_funct7), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .alu_result(alu_result),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
    .operand_a(operand_a), .operand_b(operand_b), .store_data(store_data),
    .alu_op(alu_op), .funct7(funct7), .ex_rd(ex_rd),
    .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t g;
    g.valid = ex_valid;  g.a = operand_a;   g.b = operand_b; g.sd = store_data;
    g.op = alu_op;       g.f7 = funct7;     g.rd = ex_rd;    g.rd_wen = ex_rd_wen;
    g.is_load = ex_is_load;
    return g;
  endfunction

  // Reference bypass: x0 is zero; EX (non-load) > MEM > WB > raw when bypassing is built.
  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] raw);
    if (r == 5'd0) return 32'd0;
    if (FWD) begin
      if (m.valid && m.rd_wen && !m.is_load && m.rd == r) return alu_result;
      if (mem_wen && mem_rd == r) return mem_data;
      if (wb_wen && wb_rd == r) return wb_data;
    end
    return raw;
  endfunction

  task automatic instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [2:0] op, input logic f7,
                       input logic ui, input logic upc, input logic wen, input logic ld);
    id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
    id_funct7 = f7; id_use_imm = ui; id_use_pc = upc; id_rd_wen = wen; id_is_load = ld;
    id_pc = id_pc + 32'd4;
  endtask

  // One clock: predict id_ready and the next registered state, push it, then pop and compare.
  task automatic cycle(input string tag);
    exp_t nx;
    logic adv, luh, rdy;
    #1;
    adv = !m.valid || ex_ready;
    luh = FWD && m.valid && m.is_load && m.rd != 5'd0 &&
          (id_rs1 == m.rd || (!id_use_imm && id_rs2 == m.rd));
    rdy = adv && !luh && !flush;
    chk({tag, ".id_ready"}, 128'(id_ready), 128'(rdy));
    nx = m;
    if (flush) nx = '0;
    else if (adv) begin
      nx = '0;
      if (id_valid && rdy) begin
        nx.valid   = 1'b1;
        nx.a       = id_use_pc ? id_pc : ref_fwd(id_rs1, id_rs1_data);
        nx.b       = id_use_imm ? id_imm : ref_fwd(id_rs2, id_rs2_data);
        nx.sd      = ref_fwd(id_rs2, id_rs2_data);
        nx.op      = id_alu_op;
        nx.f7      = id_use_imm ? (id_alu_op == 3'b101 && id_imm[10]) : id_funct7;
        nx.rd      = id_rd;
        nx.rd_wen  = id_rd_wen;
        nx.is_load = id_is_load;
      end
    end
    sb_q.push_back(nx);
    @(posedge clk);
    #1;
    m = sb_q.pop_front();
    chk({tag, ".out"}, 128'(dut_out()), 128'(m));
    $display("step %-12s id_ready=%0b ex_valid=%0b a=%08h b=%08h sd=%08h op=%0d f7=%0b rd=%0d",
             tag, rdy, ex_valid, operand_a, operand_b, store_data, alu_op, funct7, ex_rd);
  endtask

  initial begin
    rst_n = 1'b0; id_pc = 32'h0000_0100; ex_ready = 1'b1; flush = 1'b0;
    alu_result = '0; mem_rd = '0; mem_wen = 1'b0; mem_data = '0;
    wb_rd = '0; wb_wen = 1'b0; wb_data = '0;
    instr(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 128'(dut_out()), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("reset_id_ready", 128'(id_ready), 128'(1));

    // ADD x1 = x2 + x3, then ADD x3 = x1 + x2 with EX and MEM both targeting x1
    instr(1'b1, 5'd2, 5'd3, 5'd1, 32'hA, 32'hB, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("add_x1");
    alu_result = 32'h10; mem_rd = 5'd1; mem_wen = 1'b1; mem_data = 32'h20;
    instr(1'b1, 5'd1, 5'd2, 5'd3, 32'h111, 32'h222, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("add_fwd");
    chk("ex_wins_a", 128'(operand_a), 128'(FWD ? 32'h10 : 32'h111));
    chk("add_funct7", 128'(funct7), 128'(0));

    // LW x5, then a consumer of x5: one bubble, then issue with MEM data
    instr(1'b1, 5'd2, 5'd0, 5'd5, 32'h1000, '0, 32'd4, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("lw_x5");
    mem_rd = 5'd5; mem_data = 32'h5050;
    instr(1'b1, 5'd5, 5'd6, 5'd7, 32'h55, 32'h66, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("lu_bubble");
    chk("bubble_valid", 128'(ex_valid), 128'(!FWD));
    id_pc = id_pc - 32'd4;
    cycle("lu_issue");
    chk("lu_issue_a", 128'(operand_a), 128'(FWD ? 32'h5050 : 32'h55));
    chk("lu_issue_valid", 128'(ex_valid), 128'(1));

    // ADDI with imm bit10 set must not subtract; SRAI takes funct7 from imm[10]
    mem_wen = 1'b0;
    instr(1'b1, 5'd4, 5'd0, 5'd8, 32'h7, '0, 32'hFFFF_FC00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("addi");
    chk("addi_funct7", 128'(funct7), 128'(0));
    instr(1'b1, 5'd4, 5'd0, 5'd9, 32'h7, '0, 32'h405, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("srai");
    chk("srai_funct7", 128'(funct7), 128'(1));
    chk("srai_b", 128'(operand_b), 128'(32'h405));

    // Downstream stall for three cycles, then release
    ex_ready = 1'b0;
    instr(1'b1, 5'd10, 5'd11, 5'd12, 32'hAAAA, 32'hBBBB, '0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall");
    chk("stall_hold_b", 128'(operand_b), 128'(32'h405));
    ex_ready = 1'b1;
    cycle("release");
    chk("release_a", 128'(operand_a), 128'(32'hAAAA));

    // Flush alongside a valid instruction
    flush = 1'b1;
    instr(1'b1, 5'd13, 5'd14, 5'd15, 32'h1, 32'h2, '0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("flush");
    chk("flush_valid", 128'(ex_valid), 128'(0));
    chk("flush_rd_wen", 128'(ex_rd_wen), 128'(0));
    flush = 1'b0;

    // x0 source with matching MEM/WB entries must read zero
    mem_rd = 5'd0; mem_wen = 1'b1; mem_data = 32'hDEAD; wb_rd = 5'd0; wb_wen = 1'b1; wb_data = 32'hBEEF;
    instr(1'b1, 5'd0, 5'd3, 5'd16, 32'h1234, 32'h3, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("x0_src");
    chk("x0_a", 128'(operand_a), 128'(0));

    // Short random run over a small register set
    for (int i = 0; i < 40; i++) begin
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      alu_result = $urandom; mem_data = $urandom; wb_data = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_wen = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));  wb_wen = 1'($urandom);
      instr(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle("rand");
    end

    // Asynchronous reset mid-transfer
    ex_ready = 1'b1; flush = 1'b0;
    instr(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 128'(dut_out()), 128'(0));
    m = '0;
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 128'(id_ready), 128'(1));
    cycle("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
